// File: rtl/instr_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : instr_decode_queue
//  Brief    : Instruction field decoder feeding a DEPTH-entry valid/ready queue
//             between fetch and execute.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_decode_queue #(
   parameter int INSTR_W = 32,
   parameter int OPC_W   = 6,
   parameter int REG_W   = 5,
   parameter int SHAMT_W = 5,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [INSTR_W-1:0]            in_instr,
   input  logic [DATA_W-1:0]             in_pc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [OPC_W-1:0]              out_opcode,
   output logic [REG_W-1:0]              out_rd,
   output logic [REG_W-1:0]              out_rs,
   output logic [SHAMT_W-1:0]            out_shamt,
   output logic [INSTR_W-OPC_W-2*REG_W-SHAMT_W-1:0] out_ext,
   output logic [DATA_W-1:0]             out_imm,
   output logic [DATA_W-1:0]             out_off,
   output logic [DATA_W-1:0]             out_pc,
   output logic [$clog2(DEPTH):0]        count
);

   localparam int IMM_W = INSTR_W - OPC_W - REG_W;
   localparam int OFF_W = INSTR_W - OPC_W;
   localparam int EXT_W = INSTR_W - OPC_W - 2*REG_W - SHAMT_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = OPC_W + 2*REG_W + SHAMT_W + EXT_W + 3*DATA_W;

   localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

   if (EXT_W < 1) begin : g_chk_ext
      $error("instr_decode_queue: EXT_W must be at least 1");
   end
   if (OFF_W > DATA_W) begin : g_chk_off
      $error("instr_decode_queue: OFF_W must not exceed DATA_W");
   end
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_chk_depth
      $error("instr_decode_queue: DEPTH must be a power of 2 and >= 2");
   end

   logic [ENT_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_imm;
   logic [DATA_W-1:0] w_off;
   logic [ENT_W-1:0]  w_entry;

   assign in_ready  = (r_count != c_full);
   assign out_valid = (r_count != '0);
   assign count     = r_count;

   // Flush wins over both handshakes; the offered instruction is not taken.
   assign w_push = in_valid & in_ready & ~flush;
   assign w_pop  = out_valid & out_ready & ~flush;

   // Sized cast of a signed slice sign-extends without a zero-width replicate.
   assign w_imm = DATA_W'($signed(in_instr[IMM_W-1:0]));
   assign w_off = DATA_W'($signed(in_instr[OFF_W-1:0]));

   assign w_entry = {in_instr[INSTR_W-1 -: OPC_W],
                     in_instr[INSTR_W-OPC_W-1 -: REG_W],
                     in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W],
                     in_instr[INSTR_W-OPC_W-2*REG_W-1 -: SHAMT_W],
                     in_instr[EXT_W-1:0],
                     w_imm,
                     w_off,
                     in_pc};

   assign {out_opcode, out_rd, out_rs, out_shamt, out_ext,
           out_imm, out_off, out_pc} = r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_entry;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_decode_queue
//  Brief    : Directed self-checking bench for instr_decode_queue (defaults).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decode_queue;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  out_opcode;
   logic [4:0]  out_rd;
   logic [4:0]  out_rs;
   logic [4:0]  out_shamt;
   logic [10:0] out_ext;
   logic [31:0] out_imm;
   logic [31:0] out_off;
   logic [31:0] out_pc;
   logic [2:0]  count;

   int n_vec;
   int n_err;
   logic [31:0] exp_q[$];

   instr_decode_queue #(
      .INSTR_W (32),
      .OPC_W   (6),
      .REG_W   (5),
      .SHAMT_W (5),
      .DATA_W  (32),
      .DEPTH   (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_opcode (out_opcode),
      .out_rd     (out_rd),
      .out_rs     (out_rs),
      .out_shamt  (out_shamt),
      .out_ext    (out_ext),
      .out_imm    (out_imm),
      .out_off    (out_off),
      .out_pc     (out_pc),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance one active edge; samples taken afterwards sit 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_instr  = '0;
      in_pc     = '0;

      // Reset state
      step();
      chk("rst_count", count, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_opcode", out_opcode, 0);
      chk("rst_imm", out_imm, 0);
      chk("rst_pc", out_pc, 0);
      rst_n = 1'b1;
      step();

      // 1: single push/pop with field decode
      in_valid  = 1'b1;
      in_instr  = 32'h04A3_2805;
      in_pc     = 32'h0000_0100;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("t1_out_valid", out_valid, 1);
      chk("t1_count", count, 1);
      chk("t1_opcode", out_opcode, 6'd1);
      chk("t1_rd", out_rd, 5'd5);
      chk("t1_rs", out_rs, 5'd3);
      chk("t1_shamt", out_shamt, 5'd5);
      chk("t1_ext", out_ext, 11'h005);
      chk("t1_pc", out_pc, 32'h0000_0100);
      step();
      chk("t1_count_after_pop", count, 0);
      chk("t1_valid_after_pop", out_valid, 0);

      // 2: immediate and offset sign extension
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h0030_0000;
      in_pc     = 32'h0000_0104;
      step();
      in_valid = 1'b0;
      chk("t2_imm", out_imm, 32'hFFF0_0000);
      chk("t2_off", out_off, 32'h0030_0000);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t2_count", count, 0);

      // 3: fill to full, fifth instruction refused, drain in order across wrap
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_instr = 32'h1000_0000 + i;
         in_pc    = 32'h0000_0200 + 4 * i;
         chk($sformatf("t3_in_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
         step();
         chk($sformatf("t3_count_%0d", i), count, (i < 4) ? i + 1 : 4);
      end
      chk("t3_full_in_ready", in_ready, 0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("t3_pop_pc_%0d", j), out_pc, 32'h0000_0200 + 4 * j);
         chk($sformatf("t3_pop_ext_%0d", j), out_ext, j);
         chk($sformatf("t3_pop_opc_%0d", j), out_opcode, 6'd4);
         step();
      end
      out_ready = 1'b0;
      chk("t3_drained", count, 0);

      // 4: steady push+pop at count 2
      exp_q.delete();
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         in_instr = 32'h0800_0000 + i;
         in_pc    = 32'h0000_0400 + 4 * i;
         exp_q.push_back(in_pc);
         step();
      end
      chk("t4_count_init", count, 2);
      out_ready = 1'b1;
      for (int k = 2; k < 12; k++) begin
         in_instr = 32'h0800_0000 + k;
         in_pc    = 32'h0000_0400 + 4 * k;
         chk($sformatf("t4_head_%0d", k), out_pc, exp_q[0]);
         step();
         void'(exp_q.pop_front());
         exp_q.push_back(32'h0000_0400 + 4 * k);
         chk($sformatf("t4_count_%0d", k), count, 2);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("t4_drain_%0d", k), out_pc, exp_q[0]);
         void'(exp_q.pop_front());
         step();
      end
      out_ready = 1'b0;
      chk("t4_drained", count, 0);

      // 5: flush with an instruction offered
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_instr = 32'h0C00_0000 + i;
         in_pc    = 32'h0000_0600 + 4 * i;
         step();
      end
      chk("t5_count_pre", count, 3);
      flush    = 1'b1;
      in_instr = 32'h0C00_00FF;
      in_pc    = 32'h0000_06FC;
      chk("t5_in_ready_during_flush", in_ready, 1);
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("t5_count_post", count, 0);
      chk("t5_valid_post", out_valid, 0);
      step();
      chk("t5_not_enqueued", count, 0);

      // 6: async reset mid-stream, then resume
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_instr = 32'h1400_0000 + i;
         in_pc    = 32'h0000_0800 + 4 * i;
         step();
      end
      in_valid = 1'b0;
      chk("t6_count_pre", count, 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_count", count, 0);
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_in_ready", in_ready, 1);
      chk("t6_rst_pc", out_pc, 0);
      #1;
      rst_n = 1'b1;
      step();
      in_valid = 1'b1;
      in_instr = 32'h04A3_2805;
      in_pc    = 32'h0000_0A00;
      step();
      in_valid = 1'b0;
      chk("t6_resume_count", count, 1);
      chk("t6_resume_pc", out_pc, 32'h0000_0A00);
      chk("t6_resume_rd", out_rd, 5'd5);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t6_resume_drained", count, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
